// File: rtl/fc8_video_pkg.sv
// fc8_video_pkg: shared video timing constants and the line-fetch state encoding.
package fc8_video_pkg;
  localparam int H_ACTIVE = 256;
  localparam int H_TOTAL = 318;
  localparam int V_ACTIVE = 240;
  localparam int V_TOTAL = 262;
  localparam int MAX_OUTSTANDING = 4;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_e;
endpackage

// File: rtl/fc8_line_buf.sv
// fc8_line_buf: 2x256x8 line buffer, one write port and one registered read port.
module fc8_line_buf (
  input  logic       clk,
  input  logic       we,
  input  logic       wr_bank,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_bank,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [512];
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end
endmodule

// File: rtl/fc8_line_fetch.sv
// fc8_line_fetch: prefetches the next scanline from VRAM into a double line buffer
// while the other half feeds one colour index per pixel clock to the VGA stage.
module fc8_line_fetch
  import fc8_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  pix_index,
  output logic        pix_valid,
  output logic        underrun,
  output logic        fetch_busy
);
  fetch_state_e state, state_n;
  logic [8:0] col, col_n, wr_ptr, wr_ptr_n;
  logic [2:0] outstanding, outstanding_n, drop, drop_n;
  logic [7:0] row, row_n, scroll_x_q, scroll_y_q, disp_row, buf_data;
  logic disp_sel, fetch_line, pix_active;
  logic frame_start, trigger, swap, grant, ret, keep;

  assign frame_start = h_count == 10'd0 && v_count == 10'(V_TOTAL - 1);
  assign trigger = h_count == 10'd0 && (v_count == 10'(V_TOTAL - 1) || v_count <= 10'(V_ACTIVE - 2));
  assign swap = h_count == 10'(H_TOTAL - 1) && fetch_line;
  assign disp_row = frame_start ? 8'd0 : v_count[7:0] + 8'd1;
  assign mem_req = state == REQ && outstanding < 3'(MAX_OUTSTANDING);
  assign mem_addr = {row, col[7:0]};
  assign grant = mem_req && mem_gnt;
  assign ret = mem_rvalid && outstanding != 3'd0;
  // Reads still in flight from an aborted line are counted in drop and discarded.
  assign keep = ret && drop == 3'd0;
  assign underrun = swap && (wr_ptr != 9'd256 || state != IDLE);
  assign fetch_busy = state != IDLE;
  assign pix_valid = pix_active;
  assign pix_index = pix_active ? buf_data : 8'd0;

  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    wr_ptr_n = keep ? wr_ptr + 9'd1 : wr_ptr;
    outstanding_n = outstanding + 3'(grant) - 3'(ret);
    drop_n = ret && drop != 3'd0 ? drop - 3'd1 : drop;
    if (grant) col_n = col + 9'd1;
    if (grant && col == 9'd255) state_n = DRAIN;
    if (state == DRAIN && outstanding == 3'd0) state_n = IDLE;
    if (underrun) begin
      state_n = DRAIN;
      drop_n = outstanding_n;
    end
    if (trigger && state != REQ) begin
      state_n = REQ;
      col_n = 9'd0;
      wr_ptr_n = 9'd0;
      row_n = disp_row + (frame_start ? scroll_y : scroll_y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      col <= 9'd0;
      wr_ptr <= 9'd0;
      outstanding <= 3'd0;
      drop <= 3'd0;
      row <= 8'd0;
      disp_sel <= 1'b0;
      fetch_line <= 1'b0;
      scroll_x_q <= 8'd0;
      scroll_y_q <= 8'd0;
      pix_active <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      wr_ptr <= wr_ptr_n;
      outstanding <= outstanding_n;
      drop <= drop_n;
      row <= row_n;
      disp_sel <= swap ? ~disp_sel : disp_sel;
      fetch_line <= trigger ? 1'b1 : swap ? 1'b0 : fetch_line;
      scroll_x_q <= h_count == 10'(H_TOTAL - 1) ? scroll_x : scroll_x_q;
      scroll_y_q <= frame_start ? scroll_y : scroll_y_q;
      pix_active <= h_count < 10'(H_ACTIVE) && v_count < 10'(V_ACTIVE);
    end
  end

  fc8_line_buf u_buf (
    .clk(clk),
    .we(keep),
    .wr_bank(~disp_sel),
    .wr_addr(wr_ptr[7:0]),
    .wr_data(mem_rdata),
    .rd_bank(disp_sel),
    .rd_addr(h_count[7:0] + scroll_x_q),
    .rd_data(buf_data)
  );
endmodule

// File: doc/fc8_line_fetch.md
Name: fc8_line_fetch

Overview:
Scanline prefetch stage directly upstream of the fc8 VGA output stage. It reads each 256-pixel bitmap row from shared VRAM over a pipelined request/grant port into one half of a double line buffer while the other half is displayed. It returns one 8-bit colour index per pixel clock, indexed by the timing counters and a scroll offset. This decouples VRAM arbitration latency from pixel timing.

Parameters:
H_ACTIVE, 256, visible pixels per line
H_TOTAL, 318, pixel clocks per line
V_ACTIVE, 240, visible lines
V_TOTAL, 262, lines per frame
MAX_OUTSTANDING, 4, accepted VRAM reads awaiting rvalid

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset; synchronous, active-low
h_count  in  10  horizontal counter from timing generator
v_count  in  10  vertical counter from timing generator
scroll_x  in  8  horizontal scroll, pixels
scroll_y  in  8  vertical scroll, rows
mem_req  out  1  VRAM read request
mem_addr  out  16  VRAM byte address {row[7:0], col[7:0]}
mem_gnt  in  1  request accepted this cycle (only meaningful while mem_req=1)
mem_rvalid  in  1  read data valid; returns in request order, any latency >= 1
mem_rdata  in  8  read data
pix_index  out  8  colour index to VGA stage
pix_valid  out  1  pix_index is an active pixel
underrun  out  1  one-cycle pulse: line fetch incomplete at line end
fetch_busy  out  1  fetch FSM not IDLE

Behaviour:
- Reset (rst_n=0 sampled at clk edge): mem_req=0, mem_addr=0, pix_index=0, pix_valid=0, underrun=0, fetch_busy=0. FSM=IDLE, disp_sel=0, all counters=0, scroll latches=0. Line buffer contents undefined.
- Fetch trigger at h_count==0: v_count==V_TOTAL-1 fetches display row 0; v_count in 0..V_ACTIVE-2 fetches row v_count+1. No trigger on any other line.
- scroll_y is latched at h_count==0, v_count==V_TOTAL-1 and held for the whole frame. Fetched row = (display_row + scroll_y_q) mod 256, wraps at 8 bits.
- FSM states:
  - IDLE: on trigger, set col=0, wr_ptr=0, go to REQ.
  - REQ: mem_req=1 while outstanding<MAX_OUTSTANDING; mem_addr={row,col}. On req&gnt: col++, outstanding++. After the 256th grant, go to DRAIN.
  - DRAIN: mem_req=0; wait for outstanding==0, then go to IDLE.
- mem_addr and mem_req are held stable while mem_req=1 and mem_gnt=0.
- rvalid handling: when outstanding>0, write rdata to buffer[~disp_sel][wr_ptr], wr_ptr++, outstanding--. When outstanding==0, rvalid is ignored.
- The same-cycle grant and rvalid nets outstanding unchanged.
- Swap at h_count==H_TOTAL-1 on any line where a fetch was triggered:
  - disp_sel toggles.
  - If wr_ptr<256 or FSM!=IDLE: underrun=1 for that cycle. Remaining requests are aborted and the FSM goes to DRAIN; drained data is discarded (no buffer write).
  - The swap happens regardless of underrun.
- scroll_x is latched at h_count==H_TOTAL-1 for the next line.
- Pixel path, 1-cycle latency: on the cycle after h_count<H_ACTIVE && v_count<V_ACTIVE:
  - pix_valid=1
  - pix_index=buffer[disp_sel][(h_count+scroll_x_q) mod 256]
  - otherwise pix_index=0 and pix_valid=0.
- Throughput: full grant completes 256 reads in 256+latency cycles, well under H_TOTAL=318.
- Reset mid-fetch: mem_req=0 from that edge. rvalids arriving afterwards are ignored because outstanding==0.

Decomposition:
- Package fc8_video_pkg: H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, MAX_OUTSTANDING, and the fetch state enum (IDLE, REQ, DRAIN).
- Sub-module fc8_line_buf: 2x256x8 simple dual-port RAM, one write port and one registered read port, bank select bit. It carries the 1-cycle pixel latency.

Test Plan:
1. Reset: hold rst_n=0 three cycles mid-frame -> mem_req=0, pix_index=0, pix_valid=0, underrun=0, fetch_busy=0.
2. Basic fetch: gnt=1 always, rvalid latency 2, VRAM[a]=a[7:0]^a[15:8], scroll 0. During v=261 exactly 256 requests addr 0x0000..0x00FF. At v=0,h=5 -> next cycle pix_index=0x05, pix_valid=1, underrun never.
3. Scroll wrap: scroll_y=0x08, scroll_x=0x10. At v=0,h=250 -> pix_index=VRAM[0x080A]=0x02. At v=239 fetch row 0xF7.
4. Backpressure: gnt=1 every 3rd cycle -> underrun pulse at h=317. Late rvalids are not written, and the next line fetch issues addr from col 0.
5. Outstanding cap: gnt=1, rvalid held 0 -> exactly 4 grants, then mem_req=0. One rvalid -> mem_req=1 next cycle.
6. Reset at h=100 mid-fetch: mem_req=0 next edge, 3 stray rvalids ignored. Next frame output matches scenario 2.
